// File: rtl/gpib_listener.sv
`default_nettype none
// ============================================================================
// Module      : gpib_listener
// Description : GPIB acceptor handshake with a small receive FIFO and a
//               valid/ready host read port.
// Revision    : 1.0  initial release
// ============================================================================
module gpib_listener #(
    parameter int DATA_W        = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             bus_data,
    input  logic                          bus_dav,
    input  logic                          bus_atn,
    output logic                          nrfd,
    output logic                          ndac,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_cmd,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LVL_W-1:0] c_depth       = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ANRS = 2'd0,
        ACRS = 2'd1,
        ACDS = 2'd2,
        AWNS = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_settle_cnt;
    logic [DATA_W:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_has_space;

    assign w_has_space = (r_level < c_depth);
    // Capture happens on the edge that takes the final consecutive high sample.
    assign w_push = (r_state == ACRS) && bus_dav && (r_settle_cnt == c_settle_last);
    assign w_pop  = rx_valid && rx_ready;

    // ------------------------------------------------------------------------
    // Acceptor handshake state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ANRS;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ANRS: begin
                    r_settle_cnt <= '0;
                    if (!bus_dav && w_has_space) begin
                        r_state <= ACRS;
                    end
                end
                ACRS: begin
                    if (w_push) begin
                        r_settle_cnt <= '0;
                        r_state      <= ACDS;
                    end else if (bus_dav) begin
                        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                    end else begin
                        r_settle_cnt <= '0;
                    end
                end
                ACDS: begin
                    r_state <= AWNS;
                end
                AWNS: begin
                    if (!bus_dav) begin
                        r_state <= ANRS;
                    end
                end
                default: begin
                    r_state      <= ANRS;
                    r_settle_cnt <= '0;
                end
            endcase
        end
    end

    assign nrfd = (r_state != ACRS);
    assign ndac = (r_state != AWNS);

    // ------------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {bus_atn, bus_data};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign rx_data    = r_mem[r_rd_ptr][DATA_W-1:0];
    assign rx_cmd     = r_mem[r_rd_ptr][DATA_W];
    assign rx_valid   = (r_level != '0);
    assign fifo_level = r_level;

endmodule
`default_nettype wire
